// File: rtl/burst_writer.sv
// Burst write engine: latches a (addr, len) command, gathers len payload words
// into a local buffer, then replays them as a req/ack write burst to memory.
module burst_writer #(
  parameter  int unsigned MAX_LEN = 16,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             mem_req,
  output logic [63:0]      mem_addr,
  output logic [63:0]      mem_wdata,
  output logic             mem_last,
  input  logic             mem_ack,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_written
);

  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_BURST, S_DONE} state_t;

  state_t           r_state;
  logic [63:0]      r_base;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_fcnt;
  logic [LEN_W-1:0] r_bidx;
  bit   [63:0]      r_buf [MAX_LEN];

  logic             w_cmd_ok;
  logic             w_in_fire;
  logic             w_fill_last;
  logic             w_beat_fire;
  logic [LEN_W-1:0] w_bidx_nxt;
  logic [63:0]      w_first_data;

  assign w_cmd_ok    = (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_LEN));
  assign w_in_fire   = (r_state == S_FILL) && in_valid;
  assign w_fill_last = (r_fcnt == r_len - LEN_W'(1));
  assign w_beat_fire = mem_req && mem_ack;
  assign w_bidx_nxt  = r_bidx + LEN_W'(1);
  // For a one-word burst the only word is still on in_data when the burst starts
  assign w_first_data = (r_len == LEN_W'(1)) ? in_data : 64'(r_buf[0]);

  // Payload buffer; not reset, only indices below the current len are read
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_buf[r_fcnt[IDX_W-1:0]] <= in_data;
    end
  end

  // Control FSM with registered handshake and memory-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_base        <= '0;
      r_len         <= '0;
      r_fcnt        <= '0;
      r_bidx        <= '0;
      cmd_ready     <= 1'b1;
      in_ready      <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_last      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (w_cmd_ok) begin
              r_base    <= cmd_addr;
              r_len     <= cmd_len;
              r_fcnt    <= '0;
              r_bidx    <= '0;
              cmd_ready <= 1'b0;
              in_ready  <= 1'b1;
              r_state   <= S_FILL;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_in_fire) begin
            r_fcnt <= r_fcnt + LEN_W'(1);
            if (w_fill_last) begin
              in_ready  <= 1'b0;
              mem_req   <= 1'b1;
              mem_addr  <= r_base;
              mem_wdata <= w_first_data;
              mem_last  <= (r_len == LEN_W'(1));
              r_state   <= S_BURST;
            end
          end
        end
        S_BURST: begin
          if (w_beat_fire) begin
            if (mem_last) begin
              mem_req       <= 1'b0;
              mem_last      <= 1'b0;
              done          <= 1'b1;
              words_written <= r_len;
              r_state       <= S_DONE;
            end else begin
              r_bidx    <= w_bidx_nxt;
              mem_addr  <= r_base + 64'({w_bidx_nxt, 3'b000});
              mem_wdata <= 64'(r_buf[w_bidx_nxt[IDX_W-1:0]]);
              mem_last  <= (w_bidx_nxt == r_len - LEN_W'(1));
            end
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_writer.sv
// Scoreboard bench for burst_writer: stimulus pushes expected beats and done
// lengths into queues; a negedge monitor pops and compares them.
module tb_burst_writer;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN) + 1;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [63:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             mem_req;
  logic [63:0]      mem_addr;
  logic [63:0]      mem_wdata;
  logic             mem_last;
  logic             mem_ack;
  logic             done;
  logic             err;
  logic [LEN_W-1:0] words_written;

  beat_t beat_q[$];
  int    done_q[$];
  int    n_tests  = 0;
  int    n_fail   = 0;
  int    err_seen = 0;
  int    ack_mode = 0;
  int    cyc      = 0;

  burst_writer #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_last(mem_last),
    .mem_ack(mem_ack), .done(done), .err(err), .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event/timeout, expected none", name);
  endtask

  // Memory-side ack pattern: mode 0 = always, mode 1 = every third cycle
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (ack_mode == 0) mem_ack = 1'b1;
      else               mem_ack = ((cyc % 3) == 0);
    end
  end

  // Monitor: beats, hold stability, done timing/length, err pulses
  logic        held_v    = 1'b0;
  logic [63:0] held_a;
  logic [63:0] held_d;
  logic        held_l;
  logic        last_prev = 1'b0;
  beat_t       mb;

  always @(negedge clk) begin
    if (rst) begin
      held_v    = 1'b0;
      last_prev = 1'b0;
    end else begin
      if (done) begin
        check("done_after_last", 64'(last_prev), 64'd1);
        if (done_q.size() == 0) fail_now("unexpected_done");
        else check("words_written", 64'(words_written), 64'(done_q.pop_front()));
      end
      if (err) err_seen++;
      if (mem_req) begin
        if (held_v) begin
          check("hold_addr", mem_addr, held_a);
          check("hold_data", mem_wdata, held_d);
          check("hold_last", 64'(mem_last), 64'(held_l));
        end
        if (mem_ack) begin
          if (beat_q.size() == 0) begin
            fail_now("unexpected_beat");
          end else begin
            mb = beat_q.pop_front();
            check("beat_addr", mem_addr, mb.addr);
            check("beat_data", mem_wdata, mb.data);
            check("beat_last", 64'(mem_last), 64'(mb.last));
          end
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_a = mem_addr;
          held_d = mem_wdata;
          held_l = mem_last;
        end
      end else begin
        held_v = 1'b0;
      end
      last_prev = mem_req && mem_ack && mem_last;
    end
  end

  task automatic push_beat(input logic [63:0] a, input logic [63:0] d, input logic l);
    beat_t b;
    b.addr = a;
    b.data = d;
    b.last = l;
    beat_q.push_back(b);
  endtask

  task automatic expect_burst(input logic [63:0] a, input int n,
                              input logic [63:0] b, input logic [63:0] st);
    for (int i = 0; i < n; i++) begin
      push_beat(a + 64'(i) * 64'd8, b + 64'(i) * st, (i == n - 1));
    end
    done_q.push_back(n);
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [LEN_W-1:0] l);
    int k;
    k = 0;
    while (!cmd_ready && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!cmd_ready) fail_now("cmd_ready_timeout");
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_payload(input int n, input logic [63:0] b,
                              input logic [63:0] st, input bit gap);
    int k;
    for (int i = 0; i < n; i++) begin
      in_data  = b + 64'(i) * st;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 300) begin
        @(posedge clk);
        #1;
        k++;
      end
      if (!in_ready) begin
        fail_now("in_ready_timeout");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((beat_q.size() != 0 || done_q.size() != 0 || !cmd_ready) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 300) begin
      fail_now("burst_timeout");
      beat_q.delete();
      done_q.delete();
    end
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_mem_last", 64'(mem_last), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_words", 64'(words_written), 64'd0);

    // Streamed payload, ack tied high
    ack_mode = 0;
    expect_burst(64'h1000, 10, 64'hA0, 64'd1);
    send_cmd(64'h1000, LEN_W'(10));
    send_payload(10, 64'hA0, 64'd1, 1'b0);
    wait_idle();

    // Gapped payload, sparse ack
    ack_mode = 1;
    expect_burst(64'h1000, 10, 64'hA0, 64'd1);
    send_cmd(64'h1000, LEN_W'(10));
    send_payload(10, 64'hA0, 64'd1, 1'b1);
    wait_idle();
    ack_mode = 0;

    // Rejected lengths back to back, then a single-word burst
    send_cmd(64'h0, LEN_W'(0));
    check("err_len0", 64'(err), 64'd1);
    check("err_len0_ready", 64'(cmd_ready), 64'd1);
    send_cmd(64'h40, LEN_W'(17));
    check("err_len17", 64'(err), 64'd1);
    push_beat(64'h20, 64'h5, 1'b1);
    done_q.push_back(1);
    send_cmd(64'h20, LEN_W'(1));
    send_payload(1, 64'h5, 64'd0, 1'b0);
    wait_idle();
    check("err_count", 64'(err_seen), 64'd2);

    // Address wrap past 2^64
    push_beat(64'hFFFF_FFFF_FFFF_FFF8, 64'hC0, 1'b0);
    push_beat(64'h0000_0000_0000_0000, 64'hC1, 1'b0);
    push_beat(64'h0000_0000_0000_0008, 64'hC2, 1'b1);
    done_q.push_back(3);
    send_cmd(64'hFFFF_FFFF_FFFF_FFF8, LEN_W'(3));
    send_payload(3, 64'hC0, 64'd1, 1'b0);
    wait_idle();

    // Reset while the fourth beat is presented
    push_beat(64'h200, 64'hD0, 1'b0);
    push_beat(64'h208, 64'hD1, 1'b0);
    push_beat(64'h210, 64'hD2, 1'b0);
    send_cmd(64'h200, LEN_W'(8));
    send_payload(8, 64'hD0, 64'd1, 1'b0);
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (beat_q.size() != 0 && k < 100);
    if (k >= 100) fail_now("abort_timeout");
    #2;
    rst = 1'b1;
    #1;
    check("abort_mem_req", 64'(mem_req), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    beat_q.delete();
    expect_burst(64'h300, 2, 64'hE0, 64'd1);
    send_cmd(64'h300, LEN_W'(2));
    send_payload(2, 64'hE0, 64'd1, 1'b0);
    wait_idle();

    // Max length; a command offered mid-burst must be ignored
    expect_burst(64'h4000, 16, 64'h0, 64'h1111);
    send_cmd(64'h4000, LEN_W'(16));
    send_payload(16, 64'h0, 64'h1111, 1'b0);
    cmd_addr  = 64'h9000;
    cmd_len   = LEN_W'(2);
    cmd_valid = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    wait_idle();
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("no_second_burst_req", 64'(mem_req), 64'd0);
    check("no_second_burst_fill", 64'(in_ready), 64'd0);
    check("final_words", 64'(words_written), 64'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/burst_writer.md
# burst_writer

Synthesizable burst write engine: the write-direction counterpart of the VM's DPI burst-read path. It accepts a burst command (start address, length), gathers the payload words into an internal buffer, then issues them to the memory port as a back-to-back write burst. Each beat uses a req/ack handshake. It sits between the FHE compute datapath and the host-memory bridge.

## Interface
- MAX_LEN, 16, maximum burst length in 64-bit words; power of two, 2..256
- LEN_W, $clog2(MAX_LEN)+1, width of the length fields
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_addr  in  64  byte address of the first word
- cmd_len  in  LEN_W  burst length in words
- in_valid  in  1  payload word present
- in_ready  out  1  engine accepts payload word
- in_data  in  64  payload word
- mem_req  out  1  write beat request
- mem_addr  out  64  byte address of the current beat
- mem_wdata  out  64  data of the current beat
- mem_last  out  1  current beat is the final beat
- mem_ack  in  1  memory accepted the current beat
- done  out  1  one-cycle pulse when the burst completes
- err  out  1  one-cycle pulse when a command is rejected
- words_written  out  LEN_W  length of the last completed burst

## Operation
- States: IDLE, FILL, BURST, DONE. Reset state is IDLE.
- Registers: base address, length, fill counter fcnt, beat index bidx, and buffer[0:MAX_LEN-1] of 64-bit 2-state words.
- IDLE:
  - cmd_ready=1 and in_ready=0.
  - On cmd_valid&&cmd_ready with cmd_len==0 or cmd_len>MAX_LEN: err=1 on the next cycle, stay in IDLE, latch nothing.
  - On a valid command: latch addr and len, clear fcnt and bidx, go to FILL.
- FILL:
  - cmd_ready=0 and in_ready=1.
  - Each in_valid&&in_ready writes buffer[fcnt]<=in_data and increments fcnt.
  - Accepting the word with fcnt==len-1 moves to BURST.
  - in_valid low means wait. There is no timeout.
- BURST:
  - mem_req=1, mem_addr=base+8*bidx (mod 2^64, wraps silently), mem_wdata=buffer[bidx], mem_last=(bidx==len-1).
  - mem_ack with mem_req increments bidx.
  - mem_ack on the last beat moves to DONE.
  - mem_ack while mem_req=0 is ignored.
- DONE:
  - done=1 for exactly one cycle, words_written<=len.
  - Return to IDLE on the next cycle.
- Buffer contents are not cleared between bursts. Only indices below len are ever read.
- Address arithmetic is 64-bit unsigned; the byte offset is bidx<<3. Unaligned cmd_addr is passed through unchanged.

## Timing
- Reset values: cmd_ready=1 (IDLE), in_ready=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_last=0, done=0, err=0, words_written=0.
- Asserting rst mid-FILL or mid-BURST aborts immediately:
  - No done is produced.
  - The partial burst is lost.
  - mem_req drops asynchronously with rst.
- cmd_ready and in_ready are decoded from the registered state only, with no combinational path from any input.
- Command-to-first-mem_req latency is len+1 cycles when in_valid is held high. The first payload is accepted the cycle after the command.
- mem_addr, mem_wdata and mem_last hold stable from mem_req rise until the acked cycle. They update the cycle after ack.
- Continuous mem_ack gives one beat per cycle. A len-word burst occupies exactly len BURST cycles.
- done is asserted the cycle after the last ack. cmd_ready returns to 1 the cycle after done.
- err is asserted the cycle after the rejected handshake. cmd_ready stays 1, so back-to-back commands are allowed.
- A new command cannot overlap an active burst. cmd_valid is ignored outside IDLE.

## Test plan
- Reset, then cmd addr=0x1000 len=10, payload 0xA0..0xA9 streamed, mem_ack tied high.
  - Required: 10 beats with addr 0x1000,0x1008..0x1048 and data 0xA0..0xA9.
  - mem_last only on the beat to 0x1048.
  - done one cycle later, words_written=10.
- Same burst with in_valid toggling every other cycle and mem_ack asserted every third cycle.
  - Required: identical beat sequence.
  - mem_addr and mem_wdata stable while unacked.
- Error cases:
  - len=0 -> err pulse, no mem_req.
  - len=17 (MAX_LEN=16) -> err pulse.
  - Next cycle, len=1 addr=0x20 data 0x5 -> one beat with mem_last=1, done, words_written=1.
- Wrap-around: addr=0xFFFF_FFFF_FFFF_FFF8 len=3 -> beat addresses ...FFF8, 0x0, 0x8.
- Reset abort:
  - Assert rst during beat 4 of a len=8 burst -> mem_req=0 immediately, no done.
  - After release, a len=2 burst completes correctly with fresh data.
- Max length: len=16, data i*0x1111 -> all 16 beats correct.
  - cmd_valid pulsed during BURST is ignored; no second burst starts.
